// File: rtl/permission_read_port.sv
// rtl/permission_read_port.sv - owner-checked read port in front of an external register bank
// Optional macro PERM_SUPERVISOR_EN: requester ID 0 bypasses the owner table.
module permission_read_port #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic              own_we,
    input  logic [ADDR_W-1:0] own_addr,
    input  logic [ID_W-1:0]   own_id,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_fault,
    output logic [7:0]        fault_count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FETCH = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [ID_W-1:0]   lat_id;
    logic [ID_W-1:0]   owner [DEPTH];
    logic [WIDTH-1:0]  rsp_data_r;
    logic              rsp_fault_r;
    logic              permit;

    // The bank only ever sees the latched address, so rd_addr never follows req_addr.
    assign rd_addr = lat_addr;

`ifdef PERM_SUPERVISOR_EN
    assign permit = (lat_id == '0) || (owner[lat_addr] == lat_id);
`else
    assign permit = (owner[lat_addr] == lat_id);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nx = permit ? S_FETCH : S_RESP;
            end
            S_FETCH: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr    <= '0;
            lat_id      <= '0;
            rsp_data_r  <= '0;
            rsp_fault_r <= 1'b0;
            fault_count <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_addr <= req_addr;
                        lat_id   <= req_id;
                    end
                end
                S_CHECK: begin
                    if (!permit) begin
                        rsp_fault_r <= 1'b1;
                        rsp_data_r  <= '0;
                        if (fault_count != 8'hFF) begin
                            fault_count <= fault_count + 8'd1;
                        end
                    end
                end
                S_FETCH: begin
                    rsp_data_r  <= rd_data;
                    rsp_fault_r <= 1'b0;
                end
                S_RESP: begin
                    // Clear on handshake so the outputs read zero outside RESP.
                    if (rsp_ready) begin
                        rsp_data_r  <= '0;
                        rsp_fault_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Owner writes land at the edge that ends CHECK, so the check sees the old owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                owner[i] <= '0;
            end
        end else if (own_we) begin
            owner[own_addr] <= own_id;
        end
    end

    assign rsp_data  = rsp_data_r;
    assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_permission_read_port.sv
// tb/tb_permission_read_port.sv - randomized check of permission_read_port against an owner-table model
module tb_permission_read_port;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef PERM_SUPERVISOR_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ID_W-1:0]   req_id;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [ID_W-1:0]   own_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_fault;
    logic [7:0]        fault_count;

    logic [WIDTH-1:0]  bank [DEPTH];
    int                m_owner [DEPTH];
    int                m_fc;
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;
    assign rd_data = bank[rd_addr];

    permission_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_id(req_id),
        .own_we(own_we), .own_addr(own_addr), .own_id(own_id),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .fault_count(fault_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_owner[i] = 0;
        m_fc = 0;
    endtask

    task automatic own_write(input int a, input int id);
        @(negedge clk);
        own_we = 1'b1; own_addr = a[ADDR_W-1:0]; own_id = id[ID_W-1:0];
        @(posedge clk);
        @(negedge clk);
        own_we = 1'b0;
        m_owner[a] = id;
    endtask

    // One full transaction; optionally rewrites the owner of the same entry while in CHECK.
    task automatic do_req(input int a, input int id, input int hold, input bit wr_chk, input int wr_id,
                          input bit quiet);
        int  edges;
        bit  ok;
        logic [WIDTH-1:0] exp_data;
        @(negedge clk);
        if (!quiet) check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = a[ADDR_W-1:0]; req_id = id[ID_W-1:0]; rsp_ready = 1'b0;
        ok = (m_owner[a] == id) || (SUP && id == 0);
        exp_data = ok ? bank[a] : '0;
        if (!ok) m_fc = (m_fc < 255) ? m_fc + 1 : 255;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = ~req_addr;
        if (!quiet) check("req_ready_busy", req_ready, 0);
        if (!quiet) check("rd_addr_latched", rd_addr, a);
        if (wr_chk) begin
            own_we = 1'b1; own_addr = a[ADDR_W-1:0]; own_id = wr_id[ID_W-1:0];
        end
        while (!rsp_valid && edges < 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            own_we = 1'b0;
        end
        if (wr_chk) m_owner[a] = wr_id;
        if (!quiet || !rsp_valid) check("latency", edges, ok ? 3 : 2);
        if (!quiet || rsp_fault !== !ok) check("rsp_fault", rsp_fault, !ok);
        if (!quiet || rsp_data !== exp_data) check("rsp_data", rsp_data, exp_data);
        if (!quiet) check("fault_count", fault_count, m_fc);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, exp_data);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!quiet) begin
            check("post_valid", rsp_valid, 0);
            check("post_data", rsp_data, 0);
            check("post_fault", rsp_fault, 0);
            check("post_ready", req_ready, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_id = '0;
        own_we = 1'b0; own_addr = '0; own_id = '0; rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) bank[i] = WIDTH'($urandom);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_fault", rsp_fault, 0);
        check("rst_fc", fault_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);

        bank[5] = 8'hA5;
        do_req(5, 0, 0, 1'b0, 0, 1'b0);
        own_write(2, 3);
        do_req(2, 1, 4, 1'b0, 0, 1'b0);
        check("fc_one", fault_count, 1);
        own_write(4, 2);
        do_req(4, 0, 0, 1'b0, 0, 1'b0);
        own_write(6, 1);
        do_req(6, 1, 0, 1'b1, 2, 1'b0);
        do_req(6, 1, 0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int a;
            int id;
            bank[$urandom_range(DEPTH - 1)] = WIDTH'($urandom);
            if ($urandom_range(2) == 0) own_write($urandom_range(DEPTH - 1), $urandom_range(3));
            a  = $urandom_range(DEPTH - 1);
            id = ($urandom_range(1) == 0) ? m_owner[a] : int'($urandom_range(3));
            do_req(a, id, $urandom_range(3), $urandom_range(3) == 0, $urandom_range(3), 1'b0);
        end

        // Reset while the port is fetching.
        own_write(3, 1);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 3'd3; req_id = 2'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstf_valid", rsp_valid, 0);
        check("rstf_fc", fault_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstf_ready", req_ready, 1);
        repeat (4) @(negedge clk);
        check("rstf_no_rsp", rsp_valid, 0);
        do_req(3, 1, 0, 1'b0, 0, 1'b0);

        own_write(1, 3);
        for (int n = 0; n < 300; n++) do_req(1, 1, 0, 1'b0, 0, 1'b1);
        check("fc_saturated", fault_count, 255);
        check("fc_model", fault_count, m_fc);
        do_req(1, 2, 0, 1'b0, 0, 1'b0);
        check("fc_still_255", fault_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
